// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU front end: PC source encodings,
// sequencer state enum and the default reset PC.
// Latency: n/a (definitions only). Backpressure: n/a.
package cpu_pkg;

  // pc_src encodings; the reserved code suppresses the PC update entirely.
  localparam logic [1:0] PC_SRC_ALU_RESULT = 2'd0;  // combinational PC+4
  localparam logic [1:0] PC_SRC_ALU_OUT    = 2'd1;  // registered branch target
  localparam logic [1:0] PC_SRC_JADDR      = 2'd2;  // jump target
  localparam logic [1:0] PC_SRC_RSVD       = 2'd3;  // no update

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC source select and write qualification for the PC register.
// Latency: purely combinational. Backpressure: none; legality of the write
// against fetch state is decided by the sequencer, not here.
// Ports: pc_write/pc_write_cond/zero -> pc_en (write attempted);
//        pc_src + alu_result/alu_out/jaddr -> pc_target;
//        pc_load = pc_en with a non-reserved source.
module pc_next_mux
  import cpu_pkg::*;
(
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        zero,
  input  logic [1:0]  pc_src,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [31:0] jaddr,
  output logic        pc_en,
  output logic        pc_load,
  output logic [31:0] pc_target
);

  // An unconditional write wins regardless of zero, so OR-ing is enough.
  assign pc_en   = pc_write | (pc_write_cond & zero);
  assign pc_load = pc_en & (pc_src != PC_SRC_RSVD);

  always_comb begin
    pc_target = alu_result;
    case (pc_src)
      PC_SRC_ALU_RESULT: pc_target = alu_result;
      PC_SRC_ALU_OUT:    pc_target = alu_out;
      PC_SRC_JADDR:      pc_target = jaddr;
      default:           pc_target = alu_result;  // masked off by pc_load
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and instruction-fetch sequencer (BOOT -> FETCH -> EXEC).
// Latency: fetch request 1 cycle after next_fetch; IR/fetch_done 1 cycle after
// imem_ready. Backpressure: imem_req held until imem_ready, PC writes during a
// stalled fetch are dropped and flagged in sticky wr_drop_err.
// Ports: control (pc_write, pc_write_cond, zero, pc_src, next_fetch), data
// sources (alu_result, alu_out, jaddr), imem handshake (imem_req/addr/ready/
// rdata), state outputs (pc, cur_pc, instr, jump_field, fetch_done, wr_drop_err).
// Optional MISALIGN_TRAP_EN: misaligned targets are rejected, pulsing misalign
// and capturing bad_target; without it target bits [1:0] are cleared on load.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          BOOT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        zero,
  input  logic [1:0]  pc_src,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [31:0] jaddr,
  input  logic        next_fetch,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] cur_pc,
  output logic [31:0] instr,
  output logic [25:0] jump_field,
  output logic        fetch_done,
  output logic        wr_drop_err
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign,
  output logic [31:0] bad_target
`endif
);

  localparam logic [3:0] BOOT_LIM = 4'(BOOT_CYCLES);

  seq_state_e  state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cur_pc_q, cur_pc_d;
  logic [31:0] instr_q, instr_d;
  logic        imem_req_q, imem_req_d;
  logic        fetch_done_q, fetch_done_d;
  logic        wr_drop_err_q, wr_drop_err_d;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
  logic [31:0] bad_target_q, bad_target_d;
`endif

  logic        pc_en;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        fetch_stalled;

  pc_next_mux u_pc_next_mux (
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .zero          (zero),
    .pc_src        (pc_src),
    .alu_result    (alu_result),
    .alu_out       (alu_out),
    .jaddr         (jaddr),
    .pc_en         (pc_en),
    .pc_load       (pc_load),
    .pc_target     (pc_target)
  );

  // Only a FETCH cycle without data forbids a PC write: the address must stay
  // stable while memory is still working on it.
  assign fetch_stalled = (state_q == ST_FETCH) && !imem_ready;

  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    pc_d          = pc_q;
    cur_pc_d      = cur_pc_q;
    instr_d       = instr_q;
    imem_req_d    = imem_req_q;
    fetch_done_d  = 1'b0;
    wr_drop_err_d = wr_drop_err_q;
`ifdef MISALIGN_TRAP_EN
    misalign_d    = 1'b0;
    bad_target_d  = bad_target_q;
`endif

    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LIM) begin
          state_d    = ST_FETCH;
          imem_req_d = 1'b1;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end
      ST_FETCH: begin
        if (imem_ready) begin
          // cur_pc takes the pre-update pc; a coincident PC+4 write lands in pc.
          instr_d      = imem_rdata;
          cur_pc_d     = pc_q;
          fetch_done_d = 1'b1;
          imem_req_d   = 1'b0;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (next_fetch) begin
          state_d    = ST_FETCH;
          imem_req_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_BOOT;
        imem_req_d = 1'b0;
      end
    endcase

    if (pc_en && fetch_stalled) begin
      wr_drop_err_d = 1'b1;
    end else if (pc_load) begin
`ifdef MISALIGN_TRAP_EN
      if (pc_target[1:0] != 2'b00) begin
        misalign_d   = 1'b1;
        bad_target_d = pc_target;
      end else begin
        pc_d = pc_target;
      end
`else
      pc_d = pc_target & ~32'h3;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      boot_cnt_q    <= 4'd0;
      pc_q          <= RESET_PC;
      cur_pc_q      <= RESET_PC;
      instr_q       <= 32'h0;
      imem_req_q    <= 1'b0;
      fetch_done_q  <= 1'b0;
      wr_drop_err_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q    <= 1'b0;
      bad_target_q  <= 32'h0;
`endif
    end else begin
      state_q       <= state_d;
      boot_cnt_q    <= boot_cnt_d;
      pc_q          <= pc_d;
      cur_pc_q      <= cur_pc_d;
      instr_q       <= instr_d;
      imem_req_q    <= imem_req_d;
      fetch_done_q  <= fetch_done_d;
      wr_drop_err_q <= wr_drop_err_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q    <= misalign_d;
      bad_target_q  <= bad_target_d;
`endif
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign cur_pc      = cur_pc_q;
  assign instr       = instr_q;
  assign jump_field  = instr_q[25:0];
  assign fetch_done  = fetch_done_q;
  assign wr_drop_err = wr_drop_err_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign    = misalign_q;
  assign bad_target  = bad_target_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, boot timing, stalled fetch, dropped
// writes, branch/jump updates, misaligned targets and reset during a fetch.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_pc_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, pc_write_cond, zero, next_fetch;
  logic [1:0]  pc_src;
  logic [31:0] alu_result, alu_out, jaddr;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc, cur_pc, instr;
  logic [25:0] jump_field;
  logic        fetch_done, wr_drop_err;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
  logic [31:0] bad_target;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .BOOT_CYCLES(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .zero          (zero),
    .pc_src        (pc_src),
    .alu_result    (alu_result),
    .alu_out       (alu_out),
    .jaddr         (jaddr),
    .next_fetch    (next_fetch),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .cur_pc        (cur_pc),
    .instr         (instr),
    .jump_field    (jump_field),
    .fetch_done    (fetch_done),
    .wr_drop_err   (wr_drop_err)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign      (misalign),
    .bad_target    (bad_target)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    zero          = 1'b0;
    pc_src        = PC_SRC_ALU_RESULT;
    alu_result    = 32'h0;
    alu_out       = 32'h0;
    jaddr         = 32'h0;
    next_fetch    = 1'b0;
    imem_ready    = 1'b0;
    imem_rdata    = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick(); tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    checks++; if (cur_pc !== 32'h0) begin errors++; $display("FAIL reset_cur_pc: got %h want %h", cur_pc, 32'h0); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want %h", instr, 32'h0); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", fetch_done); end
    checks++; if (wr_drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", wr_drop_err); end
    rst_n = 1'b1;
    tick();  // first edge after release: still booting
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req_early: got %b want 0", imem_req); end
    tick();  // second edge: fetch begins
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL boot_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL boot_addr: got %h want %h", imem_addr, 32'h0); end
    tick();  // ready was high in the first FETCH cycle
    checks++; if (instr !== 32'h1234_5678) begin errors++; $display("FAIL boot_ir: got %h want %h", instr, 32'h1234_5678); end
    checks++; if (fetch_done !== 1'b1) begin errors++; $display("FAIL boot_done: got %b want 1", fetch_done); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req_drop: got %b want 0", imem_req); end
    imem_ready = 1'b0;
    tick();
    checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL boot_done_pulse: got %b want 0", fetch_done); end
  endtask

  task automatic test_delayed_fetch();
    next_fetch = 1'b1;
    tick();
    next_fetch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_req[%0d]: got %b want 1", i, imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL stall_addr[%0d]: got %h want %h", i, imem_addr, 32'h0); end
      if (i == 3) begin
        imem_ready = 1'b1;
        imem_rdata = 32'hAABB_CCDD;
        pc_write   = 1'b1;
        pc_src     = PC_SRC_ALU_RESULT;
        alu_result = 32'h4;
      end
      tick();
    end
    idle_inputs();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL if_pc: got %h want %h", pc, 32'h4); end
    checks++; if (cur_pc !== 32'h0) begin errors++; $display("FAIL if_cur_pc: got %h want %h", cur_pc, 32'h0); end
    checks++; if (instr !== 32'hAABB_CCDD) begin errors++; $display("FAIL if_ir: got %h want %h", instr, 32'hAABB_CCDD); end
    checks++; if (fetch_done !== 1'b1) begin errors++; $display("FAIL if_done: got %b want 1", fetch_done); end
    checks++; if (wr_drop_err !== 1'b0) begin errors++; $display("FAIL if_no_drop: got %b want 0", wr_drop_err); end
  endtask

  task automatic test_drop();
    next_fetch = 1'b1;
    tick();
    next_fetch = 1'b0;
    pc_write   = 1'b1;
    pc_src     = PC_SRC_ALU_RESULT;
    alu_result = 32'h100;
    tick();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL drop_pc: got %h want %h", pc, 32'h4); end
    checks++; if (wr_drop_err !== 1'b1) begin errors++; $display("FAIL drop_flag: got %b want 1", wr_drop_err); end
    idle_inputs();
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0001;
    tick();
    imem_ready = 1'b0;
    checks++; if (cur_pc !== 32'h4) begin errors++; $display("FAIL drop_cur_pc: got %h want %h", cur_pc, 32'h4); end
    checks++; if (wr_drop_err !== 1'b1) begin errors++; $display("FAIL drop_sticky: got %b want 1", wr_drop_err); end
  endtask

  task automatic test_branch();
    pc_write_cond = 1'b1;
    pc_src        = PC_SRC_ALU_OUT;
    alu_out       = 32'h40;
    zero          = 1'b0;
    tick();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL br_not_taken: got %h want %h", pc, 32'h4); end
    zero = 1'b1;
    tick();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL br_taken: got %h want %h", pc, 32'h40); end
    // Unconditional write overrides a false condition.
    pc_write = 1'b1;
    zero     = 1'b0;
    alu_out  = 32'h80;
    tick();
    checks++; if (pc !== 32'h80) begin errors++; $display("FAIL br_priority: got %h want %h", pc, 32'h80); end
    // Reserved source: no update.
    pc_src     = PC_SRC_RSVD;
    alu_result = 32'h200;
    tick();
    checks++; if (pc !== 32'h80) begin errors++; $display("FAIL src_rsvd: got %h want %h", pc, 32'h80); end
    idle_inputs();
  endtask

  task automatic test_jump();
    // PC write and next_fetch together: the fetch uses the new pc.
    pc_write   = 1'b1;
    pc_src     = PC_SRC_JADDR;
    jaddr      = 32'h3000_0000;
    next_fetch = 1'b1;
    tick();
    idle_inputs();
    checks++; if (imem_addr !== 32'h3000_0000) begin errors++; $display("FAIL wr_fetch_addr: got %h want %h", imem_addr, 32'h3000_0000); end
    imem_ready = 1'b1;
    imem_rdata = 32'h0800_0010;
    pc_write   = 1'b1;
    pc_src     = PC_SRC_ALU_RESULT;
    alu_result = 32'h3000_0004;
    tick();
    idle_inputs();
    checks++; if (pc !== 32'h3000_0004) begin errors++; $display("FAIL j_pc4: got %h want %h", pc, 32'h3000_0004); end
    checks++; if (jump_field !== 26'h000_0010) begin errors++; $display("FAIL j_field: got %h want %h", jump_field, 26'h000_0010); end
    checks++; if (cur_pc !== 32'h3000_0000) begin errors++; $display("FAIL j_cur_pc: got %h want %h", cur_pc, 32'h3000_0000); end
    pc_write = 1'b1;
    pc_src   = PC_SRC_JADDR;
    jaddr    = 32'h3000_0040;
    tick();
    idle_inputs();
    checks++; if (pc !== 32'h3000_0040) begin errors++; $display("FAIL j_pc: got %h want %h", pc, 32'h3000_0040); end
    next_fetch = 1'b1;
    tick();
    next_fetch = 1'b0;
    checks++; if (imem_addr !== 32'h3000_0040) begin errors++; $display("FAIL j_fetch_addr: got %h want %h", imem_addr, 32'h3000_0040); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL j_fetch_req: got %b want 1", imem_req); end
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0000;
    tick();
    imem_ready = 1'b0;
  endtask

  task automatic test_misalign();
    pc_write = 1'b1;
    pc_src   = PC_SRC_JADDR;
    jaddr    = 32'h0000_0042;
    tick();
    idle_inputs();
`ifdef MISALIGN_TRAP_EN
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b want 1", misalign); end
    checks++; if (bad_target !== 32'h42) begin errors++; $display("FAIL mis_target: got %h want %h", bad_target, 32'h42); end
    checks++; if (pc !== 32'h3000_0040) begin errors++; $display("FAIL mis_pc_hold: got %h want %h", pc, 32'h3000_0040); end
    tick();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse_end: got %b want 0", misalign); end
`else
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL mis_force_align: got %h want %h", pc, 32'h40); end
`endif
  endtask

  task automatic test_reset_midfetch();
    next_fetch = 1'b1;
    tick();
    next_fetch = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL mid_req_pre: got %b want 1", imem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_req_async: got %b want 0", imem_req); end
    checks++; if (wr_drop_err !== 1'b0) begin errors++; $display("FAIL mid_drop_clr: got %b want 0", wr_drop_err); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL mid_pc: got %h want %h", pc, 32'h0); end
    imem_ready = 1'b1;  // late ready arriving around reset
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL mid_late_ready: got %h want %h", instr, 32'h0); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_boot_req: got %b want 0", imem_req); end
    imem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_delayed_fetch();
    test_drop();
    test_branch();
    test_jump();
    test_misalign();
    test_reset_midfetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
